// File: rtl/vdp_cpu_port.sv
`timescale 1ns/1ps
// vdp_cpu_port: CPU-side I/O port of the VDP.
// Accepts CPU writes to a two-byte VRAM address latch (control port) and to
// a data port with address auto-increment. Data writes are queued in a small
// FIFO that drains in granted VRAM slots. CPU data reads are served from a
// one-byte read-ahead buffer; cpuWait stalls the CPU until that buffer is valid.
// Ports:
//   clk, reset                  clock, async active-high reset
//   chipSelect, regSelect       access select; regSelect 0=data, 1=control
//   writeEnabled, readEnabled   CPU strobes (write wins when both are set)
//   dataIn / dataOut            CPU data; dataOut is 0 unless a read is active
//   cpuWait                     combinational stall for the current access
//   vramAddress, vramDataOut    request address / FIFO head data
//   vramWrite, vramRead         VRAM requests (mutually exclusive)
//   vramGrant, vramDataIn       arbiter grant; read data one cycle after grant
module vdp_cpu_port #(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned VRAM_ADDR_WIDTH = 14
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       chipSelect,
  input  logic                       regSelect,
  input  logic                       writeEnabled,
  input  logic                       readEnabled,
  input  logic [7:0]                 dataIn,
  output logic [7:0]                 dataOut,
  output logic                       cpuWait,
  output logic [VRAM_ADDR_WIDTH-1:0] vramAddress,
  output logic [7:0]                 vramDataOut,
  output logic                       vramWrite,
  output logic                       vramRead,
  input  logic                       vramGrant,
  input  logic [7:0]                 vramDataIn
);

  localparam int unsigned AW = VRAM_ADDR_WIDTH;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {PH_LOW = 1'b0, PH_HIGH = 1'b1} phase_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } entry_t;

  phase_e        phase_q, phase_d;
  logic [7:0]    addr_low_q, addr_low_d;
  logic [AW-1:0] addr_ptr_q, addr_ptr_d;
  logic          mode_q, mode_d;            // 1 = write mode, 0 = read mode
  logic          valid_q, valid_d;          // read-ahead buffer holds data
  logic          pending_q, pending_d;      // prefetch wanted at addr_ptr_q
  logic          inflight_q, inflight_d;    // granted read awaiting data
  logic [7:0]    buf_q, buf_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  entry_t        fifo_mem_q [FIFO_DEPTH];

  logic fifo_full, fifo_empty, wr_acc, rd_acc, pop, push;
  entry_t head;

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head       = fifo_mem_q[rd_ptr_q];
  assign wr_acc     = chipSelect & writeEnabled;
  assign rd_acc     = chipSelect & readEnabled & ~writeEnabled;

  // Drain has priority; a prefetch only issues once the FIFO is empty.
  assign vramWrite   = ~fifo_empty;
  assign vramRead    = pending_q & fifo_empty & ~inflight_q;
  assign vramAddress = vramWrite ? head.addr : addr_ptr_q;
  assign vramDataOut = vramWrite ? head.data : 8'h00;
  assign pop         = vramWrite & vramGrant;
  // A same-cycle pop frees a slot, so a push into a full FIFO still succeeds.
  assign push        = wr_acc & ~regSelect & (~fifo_full | pop);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q    <= PH_LOW;
      addr_low_q <= 8'h00;
      addr_ptr_q <= '0;
      mode_q     <= 1'b1;
      valid_q    <= 1'b0;
      pending_q  <= 1'b0;
      inflight_q <= 1'b0;
      buf_q      <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      phase_q    <= phase_d;
      addr_low_q <= addr_low_d;
      addr_ptr_q <= addr_ptr_d;
      mode_q     <= mode_d;
      valid_q    <= valid_d;
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
      buf_q      <= buf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; contents are only observed through the count, so no reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= '{addr: addr_ptr_q, data: dataIn};
  end

  // Next-state and CPU-side outputs.
  always_comb begin
    phase_d    = phase_q;
    addr_low_d = addr_low_q;
    addr_ptr_d = addr_ptr_q;
    mode_d     = mode_q;
    valid_d    = valid_q;
    pending_d  = pending_q;
    inflight_d = inflight_q;
    buf_d      = buf_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    dataOut    = 8'h00;
    cpuWait    = 1'b0;

    // Read data returns one cycle after the grant.
    if (inflight_q) begin
      buf_d      = vramDataIn;
      valid_d    = 1'b1;
      pending_d  = 1'b0;
      inflight_d = 1'b0;
    end
    if (vramRead && vramGrant) inflight_d = 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);

    // Later assignments to valid/inflight override the return path: a cancel wins.
    if (wr_acc && regSelect) begin
      if (phase_q == PH_LOW) begin
        addr_low_d = dataIn;
        phase_d    = PH_HIGH;
      end else begin
        addr_ptr_d = {dataIn[AW-9:0], addr_low_q};
        mode_d     = dataIn[6];
        phase_d    = PH_LOW;
        if (!dataIn[6]) begin
          valid_d    = 1'b0;
          inflight_d = 1'b0;
          pending_d  = 1'b1;
        end
      end
    end else if (wr_acc && !regSelect) begin
      if (push) begin
        addr_ptr_d = addr_ptr_q + AW'(1);
        valid_d    = 1'b0;
        inflight_d = 1'b0;
        if (!mode_q) pending_d = 1'b1;
      end else begin
        cpuWait = 1'b1;
      end
    end else if (rd_acc && regSelect) begin
      dataOut = {fifo_full, fifo_empty, valid_q, 4'b0000, phase_q == PH_HIGH};
      phase_d = PH_LOW;
    end else if (rd_acc && !regSelect) begin
      if (valid_q) begin
        dataOut    = buf_q;
        valid_d    = 1'b0;
        addr_ptr_d = addr_ptr_q + AW'(1);
        pending_d  = 1'b1;
      end else begin
        cpuWait = 1'b1;
      end
    end
  end

endmodule
